// File: rtl/xor_parity_sched.sv
// xor_parity_sched
//
// Round-robin scheduler that shares a single bit-serial XOR2 reduction engine
// among N_REQ requesters. A granted requester's WIDTH-bit word is captured,
// then shifted out LSB first, one bit per clock, into a one-bit accumulator.
// The accumulator ends up holding the parity (XOR of all bits) of the word.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_req     : per-requester request level (N_REQ bits)
//   in_data    : requester k's word at [k*WIDTH +: WIDTH]
//   out_gnt    : one-hot grant pulse, one cycle, marks data capture
//   out_id     : index of the requester currently or last served
//   out_busy   : high while shifting and in the done cycle
//   out_done   : one-cycle pulse when out_parity is valid
//   out_parity : parity of the served word, held until the next out_done
//
// All outputs are registered; there is no combinational input-to-output path.

module xor_parity_sched #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         in_req,
  input  logic [N_REQ*WIDTH-1:0]   in_data,
  output logic [N_REQ-1:0]         out_gnt,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_busy,
  output logic                     out_done,
  output logic                     out_parity
);

  // Counter is one bit wider than strictly needed so it can never wrap.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [ID_W-1:0] LastRst = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              parity_q, parity_d;

  // Arbitration results
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [WIDTH-1:0]  win_word;
  logic              xor_bit;

  // Round-robin search: candidates last+1, last+2, ... wrapping modulo N_REQ,
  // so the previously served requester is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((32'(last_q) + off) % N_REQ);
      if (!win_found && in_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Word mux for the winner; constant slices keep the select width-clean.
  always_comb begin
    win_word = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        win_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // The one shared XOR2 operation of the engine.
  assign xor_bit = acc_q ^ shreg_q[0];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    id_d     = id_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    parity_d = parity_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          shreg_d = win_word;
          acc_d   = 1'b0;
          cnt_d   = '0;
          gnt_d   = N_REQ'(1) << win_idx;
          id_d    = win_idx;
          last_d  = win_idx;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d   = xor_bit;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          parity_d = xor_bit;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= LastRst;
      shreg_q  <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      parity_q <= parity_d;
    end
  end

  assign out_gnt    = gnt_q;
  assign out_id     = id_q;
  assign out_busy   = busy_q;
  assign out_done   = done_q;
  assign out_parity = parity_q;

endmodule

// File: tb/tb_xor_parity_sched.sv
module tb_xor_parity_sched;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ID_W  = 1;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       in_req;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       out_gnt;
  logic [ID_W-1:0]        out_id;
  logic                   out_busy;
  logic                   out_done;
  logic                   out_parity;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Scoreboard entry: id*2 + expected parity.
  int sb_q[$];

  xor_parity_sched #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .ID_W (ID_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_data   (in_data),
    .out_gnt   (out_gnt),
    .out_id    (out_id),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_parity(out_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int k, input logic [WIDTH-1:0] w);
    sb_q.push_back(k * 2 + int'(^w));
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (out_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(out_done), 32'd0);
      end else begin
        int e;
        e = sb_q.pop_front();
        chk("sb_id", 32'(out_id), 32'(e >> 1));
        chk("sb_parity", 32'(out_parity), 32'(e & 1));
      end
    end
  end

  // Wait (bounded) for out_done; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (out_done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (out_done !== 1'b1) chk("busy_shift", 32'(out_busy), 32'd1);
    end
  endtask

  // One isolated request from requester k; leaves the bench in the IDLE
  // cycle right after DONE.
  task automatic serve(input int k, input logic [WIDTH-1:0] w, output int done_cyc);
    int n;
    in_req = '0;
    in_req[k] = 1'b1;
    in_data[k*WIDTH +: WIDTH] = w;
    sb_push(k, w);
    tick();
    in_req = '0;
    chk("gnt", 32'(out_gnt), 32'(1 << k));
    chk("busy_at_gnt", 32'(out_busy), 32'd1);
    wait_done(n);
    chk("latency", 32'(n), 32'(WIDTH));
    chk("busy_at_done", 32'(out_busy), 32'd1);
    done_cyc = cyc;
    tick();
    chk("done_pulse_one_cycle", 32'(out_done), 32'd0);
    chk("busy_idle", 32'(out_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, d3, n;
    logic quiet;
    rst     = 1'b1;
    in_req  = '0;
    in_data = '0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", 32'(out_gnt), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_parity", 32'(out_parity), 32'd0);
    rst = 1'b0;

    // Single requester, 8'hB5 -> parity 1
    serve(0, 8'hB5, d1);
    chk("single_parity", 32'(out_parity), 32'd1);

    // Parity values on requester 1, back to back
    serve(1, 8'h3C, d1);
    serve(1, 8'hFF, d2);
    serve(1, 8'h00, d3);
    chk("spacing_1", 32'(d2 - d1), 32'(WIDTH + 2));
    chk("spacing_2", 32'(d3 - d2), 32'(WIDTH + 2));

    // Contention: both held, last served was 1 so order is 0,1,0,1
    in_data[0*WIDTH +: WIDTH] = 8'h01;
    in_data[1*WIDTH +: WIDTH] = 8'h03;
    in_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sb_push(i % 2, (i % 2 == 0) ? 8'h01 : 8'h03);
    end
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (out_gnt == '0 && n < 40) begin
        tick();
        n++;
      end
      chk("rr_gnt", 32'(out_gnt), 32'(1 << (i % 2)));
      wait_done(n);
      chk("rr_latency", 32'(n), 32'(WIDTH));
    end
    in_req = '0;
    tick();
    tick();
    chk("rr_no_extra_gnt", 32'(out_gnt), 32'd0);
    chk("rr_idle_busy", 32'(out_busy), 32'd0);

    // Capture isolation: 8'h07 captured, edited to 8'hFF in cycle 3
    in_data[0*WIDTH +: WIDTH] = 8'h07;
    in_req = 2'b01;
    sb_push(0, 8'h07);
    tick();
    in_req = '0;
    chk("iso_gnt", 32'(out_gnt), 32'd1);
    tick();
    tick();
    in_data[0*WIDTH +: WIDTH] = 8'hFF;
    wait_done(n);
    chk("iso_parity", 32'(out_parity), 32'd1);
    tick();

    // Reset mid-operation on requester 1
    in_data[1*WIDTH +: WIDTH] = 8'h80;
    in_req = 2'b10;
    tick();
    in_req = '0;
    chk("rstmid_gnt", 32'(out_gnt), 32'd2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_gnt0", 32'(out_gnt), 32'd0);
    chk("rstmid_id0", 32'(out_id), 32'd0);
    chk("rstmid_busy0", 32'(out_busy), 32'd0);
    chk("rstmid_done0", 32'(out_done), 32'd0);
    chk("rstmid_parity0", 32'(out_parity), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_done !== 1'b0 || out_busy !== 1'b0) quiet = 1'b0;
    end
    chk("rstmid_quiet", 32'(quiet), 32'd1);
    // Pointer reset: requester 0 wins first
    in_data[0*WIDTH +: WIDTH] = 8'h0B;
    in_data[1*WIDTH +: WIDTH] = 8'h01;
    in_req = 2'b11;
    sb_push(0, 8'h0B);
    tick();
    in_req = '0;
    chk("rstmid_first_gnt", 32'(out_gnt), 32'd1);
    wait_done(n);
    tick();

    // Late request: req 1 raised during SHIFT of req 0
    in_data[0*WIDTH +: WIDTH] = 8'h0F;
    in_req = 2'b01;
    sb_push(0, 8'h0F);
    tick();
    in_req = '0;
    chk("late_gnt0", 32'(out_gnt), 32'd1);
    tick();
    tick();
    in_data[1*WIDTH +: WIDTH] = 8'h0E;
    in_req = 2'b10;
    sb_push(1, 8'h0E);
    wait_done(n);
    tick();
    chk("late_idle_gnt", 32'(out_gnt), 32'd0);
    chk("late_idle_busy", 32'(out_busy), 32'd0);
    tick();
    in_req = '0;
    chk("late_gnt1", 32'(out_gnt), 32'd2);
    wait_done(n);
    chk("late_latency", 32'(n), 32'(WIDTH));
    tick();
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_parity_sched.md
# xor_parity_sched

Round-robin scheduler that shares one bit-serial 2-input XOR reduction engine among `N_REQ` requesters, computing the parity (XOR of all bits) of each granted requester's `WIDTH`-bit word. It sits above the XOR2 gate primitive and sequences it one bit per clock.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `WIDTH`, default 8: data word width, 2..32.
- `ID_W`, default `max(1, $clog2(N_REQ))`: width of the grant index.
- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_req`: input, `N_REQ` bits. Per-requester request level.
- `in_data`: input, `N_REQ*WIDTH` bits. Requester k's word is at `[k*WIDTH +: WIDTH]`.
- `out_gnt`: output, `N_REQ` bits. One-hot grant pulse, one cycle, marking data capture.
- `out_id`: output, `ID_W` bits. Index of the requester currently or last served.
- `out_busy`: output, 1 bit. High in SHIFT and DONE.
- `out_done`: output, 1 bit. One-cycle pulse when `out_parity` is valid.
- `out_parity`: output, 1 bit. XOR of all bits of the served word, held until the next `out_done`.

## Operation
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- **IDLE**
  - If `in_req` is nonzero, choose a winner round-robin. The search starts at `last+1` modulo `N_REQ`, where `last` is the previously granted index.
  - On the edge: `shreg <= winner's word`, `acc <= 0`, `cnt <= 0`, `out_gnt <= onehot(winner)`, `out_id <= winner`, `last <= winner`, state becomes SHIFT.
  - If `in_req` is zero, remain in IDLE.
- **SHIFT**
  - Each edge: `acc <= acc ^ shreg[0]` (the single XOR2 operation), `shreg <= shreg >> 1`, `cnt <= cnt + 1`.
  - On the edge where `cnt == WIDTH-1`: `out_parity <= acc ^ shreg[0]`, `out_done <= 1`, state becomes DONE.
  - `cnt` width is `$clog2(WIDTH)+1`; it never wraps.
- **DONE**
  - `out_done` is high for this cycle only.
  - On the next edge, state becomes IDLE and `out_done <= 0`.
- `out_gnt` is cleared on the edge after it is set.
- `in_req` and `in_data` are ignored outside IDLE.
  - The word is captured at grant; later changes to `in_data` do not affect the result.
  - A requester that drops `in_req` mid-operation is still served to completion.
- Requesters hold `in_req` until they see their `out_gnt` bit. They deassert it the cycle after if no further work is pending. A held request is re-arbitrated and served again.
- Reset values: state IDLE, `out_gnt` = 0, `out_id` = 0, `out_busy` = 0, `out_done` = 0, `out_parity` = 0, `last = N_REQ-1` (requester 0 wins first), `acc` = 0, `shreg` = 0, `cnt` = 0.
- Reset asserted in any state:
  - Aborts the operation on that edge, with no `out_done` and no `out_parity` update.
  - Resets the pointer.
  - Reset has priority over every transition.

## Timing
- Request sampled in IDLE at cycle 0:
  - `out_gnt` and `out_busy` are high in cycle 1.
  - SHIFT occupies cycles 1..WIDTH.
  - `out_done` and the new `out_parity` are valid in cycle WIDTH+1.
  - IDLE is in cycle WIDTH+2.
- Latency is WIDTH+1 cycles from request sample to `out_done`. Minimum issue interval is WIDTH+2 cycles.
- No combinational path from any input to any output.
- Simultaneous requests: exactly one grant per arbitration. With all requesters held continuously, grants rotate 0, 1, …, N_REQ-1, 0, …
- A request arriving during SHIFT or DONE waits. It is considered at the first IDLE cycle.

## Test plan
- **Single requester.** `rst` for 2 cycles, then `in_req = 2'b01`, `in_data[7:0] = 8'hB5` for one cycle.
  - Required: `out_gnt = 01` in cycle 1, `out_busy` high cycles 1–9, `out_done` pulse in cycle 9, `out_parity = 1`, `out_id = 0`.
- **Parity values.** Requester 1 with `8'h3C`, then `8'hFF`, then `8'h00`.
  - Required: `out_parity = 0` for each, `out_id = 1`, `out_done` spaced 10 cycles apart.
- **Contention.** Both requests held high with words `8'h01` (req 0) and `8'h03` (req 1) for 4 operations.
  - Required: grant order 0, 1, 0, 1; parities 1, 0, 1, 0.
- **Capture isolation.** Change `in_data` of the granted requester in cycle 3 to `8'hFF` after capturing `8'h07`.
  - Required: `out_parity = 1`, unchanged by the edit.
- **Reset mid-operation.** Assert `rst` during SHIFT in cycle 4 for one cycle.
  - Required: no `out_done`, all outputs 0 next cycle.
  - Then both requests: requester 0 is granted first.
- **Late request.** Raise `in_req[1]` during SHIFT of requester 0.
  - Required: grant to 1 occurs in the cycle after the first IDLE cycle following DONE.
